// File: rtl/enemy_pkg.sv
// ---------------------------------------------------------------------------
// enemy_pkg
// Shared constants for the patrolling enemy: FSM state encodings, walking
// direction values, collision flag bit positions, and the field offsets of
// the packed enemy state word {x_pos, y_pos, x_spd, y_spd, dir, active}.
// ---------------------------------------------------------------------------
package enemy_pkg;

  // FSM state encodings, as seen on the mode output
  localparam logic [2:0] WALK    = 3'd0;
  localparam logic [2:0] TURN    = 3'd1;
  localparam logic [2:0] STUNNED = 3'd2;
  localparam logic [2:0] DEAD    = 3'd3;

  // Walking direction
  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  // Bit positions inside the col input {ceiling, floor, right, left}
  localparam int COL_LEFT  = 0;
  localparam int COL_RIGHT = 1;
  localparam int COL_FLOOR = 2;
  localparam int COL_CEIL  = 3;

  // Default tile size is 32 px
  localparam int DEFAULT_TILE_LOG2 = 5;

  // Fixed low fields of the packed state word
  localparam int ST_ACTIVE_OFS = 0;
  localparam int ST_DIR_OFS    = 1;
  localparam int ST_YSPD_OFS   = 2;

  // Offsets of the width-dependent fields
  function automatic int stXSpdOfs(input int spdW);
    return 2 + spdW;
  endfunction

  function automatic int stYPosOfs(input int spdW);
    return 2 + 2 * spdW;
  endfunction

  function automatic int stXPosOfs(input int posW, input int spdW);
    return 2 + 2 * spdW + posW;
  endfunction

endpackage

// File: rtl/tile_snap.sv
// ---------------------------------------------------------------------------
// tile_snap
// Combinational tile-boundary snap. Moves pos by spd in the given direction,
// then aligns the result to the tile edge that was just hit:
//   toward positive: last pixel before the tile boundary (base - 1)
//   toward negative: first pixel of the next tile (base + T)
// Ports:
//   pos            current coordinate
//   spd            unsigned step size
//   towardPositive 1 = moving toward larger coordinates
//   snapped        aligned coordinate
// ---------------------------------------------------------------------------
module tile_snap #(
  parameter int POS_W     = 10,
  parameter int SPD_W     = 5,
  parameter int TILE_LOG2 = 5
) (
  input  logic [POS_W-1:0] pos,
  input  logic [SPD_W-1:0] spd,
  input  logic             towardPositive,
  output logic [POS_W-1:0] snapped
);

  localparam logic [POS_W-1:0] TILE = POS_W'(1) << TILE_LOG2;
  localparam logic [POS_W-1:0] MASK = TILE - POS_W'(1);

  logic [POS_W-1:0] moved;
  logic [POS_W-1:0] tileBase;

  assign moved    = towardPositive ? pos + POS_W'(spd) : pos - POS_W'(spd);
  // Clearing the low bits is the same as subtracting (moved & MASK)
  assign tileBase = moved & ~MASK;
  assign snapped  = towardPositive ? tileBase - POS_W'(1) : tileBase + TILE;

endmodule

// File: rtl/enemy_walker.sv
// ---------------------------------------------------------------------------
// enemy_walker
// Patrolling ground enemy, updated once per game frame. Walks left/right,
// pauses and turns on wall contact, falls under gravity, lands on floors,
// takes stomp hits (stun, then defeat).
//
// Optional feature macro: ENEMY_LEDGE_TURN_EN
//   When defined, adds input ledge_ahead; a grounded walker that sees no
//   floor one tile ahead turns around instead of walking off.
//
// Ports:
//   sim_clk      frame clock
//   reset_n      synchronous active-low reset
//   col          collision flags {ceiling, floor, right, left}
//   hit          one-frame stomp pulse
//   ledge_ahead  (ENEMY_LEDGE_TURN_EN only) no floor one tile ahead
//   enemy_state  {x_pos, y_pos, x_spd, y_spd, dir, active}
//   mode         current FSM state
//   hp           remaining hit points
// ---------------------------------------------------------------------------
module enemy_walker
  import enemy_pkg::*;
#(
  parameter int POS_W       = 10,
  parameter int SPD_W       = 5,
  parameter int TILE_LOG2   = DEFAULT_TILE_LOG2,
  parameter int INIT_X      = 450,
  parameter int INIT_Y      = 150,
  parameter int WALK_SPEED  = 3,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 8,
  parameter int TURN_PAUSE  = 8,
  parameter int STUN_FRAMES = 60,
  parameter int HP_INIT     = 2
) (
  input  logic                       sim_clk,
  input  logic                       reset_n,
  input  logic [3:0]                 col,
  input  logic                       hit,
`ifdef ENEMY_LEDGE_TURN_EN
  input  logic                       ledge_ahead,
`endif
  output logic [2*POS_W+2*SPD_W+1:0] enemy_state,
  output logic [2:0]                 mode,
  output logic [1:0]                 hp
);

  localparam int TURN_W = $clog2(TURN_PAUSE + 1);
  localparam int STUN_W = $clog2(STUN_FRAMES + 1);

  localparam logic [SPD_W-1:0] WALK_SPD = SPD_W'(WALK_SPEED);

  logic [POS_W-1:0]  xPos, xNext;
  logic [POS_W-1:0]  yPos, yNext;
  logic [SPD_W-1:0]  ySpd, ySpdNext;
  logic              dir, dirNext;
  logic [1:0]        hpReg, hpNext;
  logic [2:0]        modeReg, modeNext;
  logic [TURN_W-1:0] turnTimer, turnNext;
  logic [STUN_W-1:0] stunTimer, stunNext;

  logic [POS_W-1:0]  xSnapped;
  logic [POS_W-1:0]  ySnapped;
  logic [SPD_W:0]    ySpdInc;
  logic [SPD_W-1:0]  ySpdFall;
  logic              wallHit;
  logic              ledgeTurn;
  logic              active;
  logic [SPD_W-1:0]  xSpdField;

  // Wall snap follows the current walking direction
  tile_snap #(.POS_W(POS_W), .SPD_W(SPD_W), .TILE_LOG2(TILE_LOG2)) xSnap (
    .pos            (xPos),
    .spd            (WALK_SPD),
    .towardPositive (dir),
    .snapped        (xSnapped)
  );

  // Floor snap: falling is always toward larger y
  tile_snap #(.POS_W(POS_W), .SPD_W(SPD_W), .TILE_LOG2(TILE_LOG2)) ySnap (
    .pos            (yPos),
    .spd            (ySpd),
    .towardPositive (1'b1),
    .snapped        (ySnapped)
  );

  assign wallHit = col[COL_LEFT] | col[COL_RIGHT];

`ifdef ENEMY_LEDGE_TURN_EN
  assign ledgeTurn = col[COL_FLOOR] & ledge_ahead;
`else
  assign ledgeTurn = 1'b0;
`endif

  // Gravity step, saturating at the terminal fall speed
  assign ySpdInc  = {1'b0, ySpd} + (SPD_W+1)'(GRAVITY);
  assign ySpdFall = (ySpdInc >= (SPD_W+1)'(MAX_FALL)) ? SPD_W'(MAX_FALL)
                                                      : ySpdInc[SPD_W-1:0];

  always_comb begin
    xNext    = xPos;
    yNext    = yPos;
    ySpdNext = ySpd;
    dirNext  = dir;
    hpNext   = hpReg;
    modeNext = modeReg;
    turnNext = turnTimer;
    stunNext = stunTimer;

    // Vertical motion runs in every state except DEAD
    if (modeReg != DEAD) begin
      if (col[COL_FLOOR]) begin
        if (ySpd != '0) begin
          yNext    = ySnapped;
          ySpdNext = '0;
        end
      end else begin
        yNext    = yPos + POS_W'(ySpd);
        ySpdNext = ySpdFall;
      end
      if (col[COL_CEIL]) begin
        ySpdNext = '0;
      end
    end

    case (modeReg)
      WALK, TURN: begin
        // A stomp overrides walls, ledges and the turn pause; x holds
        if (hit) begin
          if (hpReg > 2'd1) begin
            hpNext   = hpReg - 2'd1;
            modeNext = STUNNED;
            stunNext = '0;
          end else begin
            hpNext   = 2'd0;
            modeNext = DEAD;
          end
        end else if (modeReg == WALK) begin
          if (wallHit) begin
            xNext    = xSnapped;
            modeNext = TURN;
            turnNext = '0;
          end else if (ledgeTurn) begin
            modeNext = TURN;
            turnNext = '0;
          end else begin
            xNext = (dir == RIGHT) ? xPos + POS_W'(WALK_SPEED)
                                   : xPos - POS_W'(WALK_SPEED);
          end
        end else begin
          if (turnTimer == TURN_W'(TURN_PAUSE - 1)) begin
            dirNext  = ~dir;
            modeNext = WALK;
            turnNext = '0;
          end else begin
            turnNext = turnTimer + TURN_W'(1);
          end
        end
      end
      STUNNED: begin
        if (stunTimer == STUN_W'(STUN_FRAMES - 1)) begin
          modeNext = WALK;
          stunNext = '0;
        end else begin
          stunNext = stunTimer + STUN_W'(1);
        end
      end
      DEAD: begin
        modeNext = DEAD;
      end
      default: begin
        modeNext = WALK;
      end
    endcase
  end

  // Frame register; reset wins over every other input
  always_ff @(posedge sim_clk) begin
    if (!reset_n) begin
      xPos      <= POS_W'(INIT_X);
      yPos      <= POS_W'(INIT_Y);
      ySpd      <= '0;
      dir       <= RIGHT;
      hpReg     <= 2'(HP_INIT);
      modeReg   <= WALK;
      turnTimer <= '0;
      stunTimer <= '0;
    end else begin
      xPos      <= xNext;
      yPos      <= yNext;
      ySpd      <= ySpdNext;
      dir       <= dirNext;
      hpReg     <= hpNext;
      modeReg   <= modeNext;
      turnTimer <= turnNext;
      stunTimer <= stunNext;
    end
  end

  assign active    = (modeReg != DEAD);
  // Renderer expects a zero horizontal speed whenever the enemy is not walking
  assign xSpdField = (modeReg == WALK) ? WALK_SPD : '0;

  assign enemy_state = {xPos, yPos, xSpdField, ySpd, dir, active};
  assign mode        = modeReg;
  assign hp          = hpReg;

endmodule

// File: tb/tb_enemy_walker.sv
// ---------------------------------------------------------------------------
// tb_enemy_walker
// Self-checking bench for enemy_walker at default parameters. A table of
// frame vectors {inputs, expected outputs} is replayed from reset, followed
// by hand-written sequences for reset during stun/turn and the ledge feature.
// ---------------------------------------------------------------------------
module tb_enemy_walker;
  import enemy_pkg::*;

  logic        sim_clk = 1'b0;
  logic        resetN;
  logic [3:0]  col;
  logic        hit;
`ifdef ENEMY_LEDGE_TURN_EN
  logic        ledgeAhead;
`endif
  logic [31:0] enemyState;
  logic [2:0]  mode;
  logic [1:0]  hp;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        resetN;
    logic [3:0]  col;
    logic        hit;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [4:0]  ySpd;
    logic        dir;
    logic        active;
    logic [2:0]  mode;
    logic [1:0]  hp;
  } vec_t;

  vec_t vecs[$];

  always #5 sim_clk = ~sim_clk;

  enemy_walker dut (
    .sim_clk     (sim_clk),
    .reset_n     (resetN),
    .col         (col),
    .hit         (hit),
`ifdef ENEMY_LEDGE_TURN_EN
    .ledge_ahead (ledgeAhead),
`endif
    .enemy_state (enemyState),
    .mode        (mode),
    .hp          (hp)
  );

  function automatic void addVec(input logic r, input logic [3:0] c, input logic h,
                                 input int x, input int y, input int ys,
                                 input logic d, input logic a,
                                 input logic [2:0] m, input int hpv);
    vec_t v;
    v.resetN = r;
    v.col    = c;
    v.hit    = h;
    v.x      = 10'(x);
    v.y      = 10'(y);
    v.ySpd   = 5'(ys);
    v.dir    = d;
    v.active = a;
    v.mode   = m;
    v.hp     = 2'(hpv);
    vecs.push_back(v);
  endfunction

  // Drive one frame's inputs on the falling edge, sample 1 ns after the rise
  task automatic applyStimulus(input logic r, input logic [3:0] c, input logic h);
    @(negedge sim_clk);
    resetN = r;
    col    = c;
    hit    = h;
    @(posedge sim_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] ex, input logic [9:0] ey,
                             input logic [4:0] eys, input logic ed, input logic ea,
                             input logic [2:0] em, input logic [1:0] ehp);
    logic [4:0]  exs;
    logic [31:0] expWord;
    exs     = (em == WALK) ? 5'd3 : 5'd0;
    expWord = {ex, ey, exs, eys, ed, ea};
    checks++;
    if (enemyState !== expWord) begin
      failures++;
      $display("[TB] FAIL %s state: got x=%0d y=%0d xs=%0d ys=%0d dir=%0b act=%0b, want x=%0d y=%0d xs=%0d ys=%0d dir=%0b act=%0b",
               tag, enemyState[31:22], enemyState[21:12], enemyState[11:7], enemyState[6:2],
               enemyState[1], enemyState[0], ex, ey, exs, eys, ed, ea);
    end
    checks++;
    if (mode !== em) begin
      failures++;
      $display("[TB] FAIL %s mode: got %0d, want %0d", tag, mode, em);
    end
    checks++;
    if (hp !== ehp) begin
      failures++;
      $display("[TB] FAIL %s hp: got %0d, want %0d", tag, hp, ehp);
    end
  endtask

  initial begin
    int fallY[10]  = '{150, 151, 153, 156, 160, 165, 171, 178, 186, 194};
    int fallYs[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};

    resetN = 1'b0;
    col    = 4'b0000;
    hit    = 1'b0;
`ifdef ENEMY_LEDGE_TURN_EN
    ledgeAhead = 1'b0;
`endif

    // ---------------- vector table ----------------
    addVec(0, 4'b0000, 0, 450, 150, 0, 1, 1, WALK, 2);      // 0 reset
    addVec(1, 4'b0000, 0, 453, 150, 1, 1, 1, WALK, 2);      // 1 first frame
    addVec(1, 4'b0010, 0, 447, 151, 2, 1, 1, TURN, 2);      // 2 right wall snap
    addVec(1, 4'b0100, 0, 447, 127, 0, 1, 1, TURN, 2);      // 3 land 153 -> 127
    for (int k = 0; k < 6; k++)
      addVec(1, 4'b0100, 0, 447, 127, 0, 1, 1, TURN, 2);    // 4..9 pause
    addVec(1, 4'b0100, 0, 447, 127, 0, 0, 1, WALK, 2);      // 10 reversed
    addVec(1, 4'b0100, 0, 444, 127, 0, 0, 1, WALK, 2);      // 11 walk left
    addVec(1, 4'b0111, 0, 448, 127, 0, 0, 1, TURN, 2);      // 12 both walls, left snap
    addVec(1, 4'b0110, 0, 448, 127, 0, 0, 1, TURN, 2);      // 13 walls ignored in TURN
    for (int k = 0; k < 6; k++)
      addVec(1, 4'b0100, 0, 448, 127, 0, 0, 1, TURN, 2);    // 14..19
    addVec(1, 4'b0100, 0, 448, 127, 0, 1, 1, WALK, 2);      // 20 reversed
    addVec(1, 4'b0100, 0, 451, 127, 0, 1, 1, WALK, 2);      // 21
    addVec(1, 4'b0100, 1, 451, 127, 0, 1, 1, STUNNED, 1);   // 22 first stomp
    addVec(1, 4'b0000, 0, 451, 127, 1, 1, 1, STUNNED, 1);   // 23 gravity in stun
    addVec(1, 4'b0000, 0, 451, 128, 2, 1, 1, STUNNED, 1);   // 24
    addVec(1, 4'b0000, 1, 451, 130, 3, 1, 1, STUNNED, 1);   // 25 hit ignored
    addVec(1, 4'b0100, 0, 451, 127, 0, 1, 1, STUNNED, 1);   // 26 land 133 -> 127
    for (int k = 0; k < 55; k++)
      addVec(1, 4'b0100, 0, 451, 127, 0, 1, 1, STUNNED, 1); // 27..81
    addVec(1, 4'b0100, 0, 451, 127, 0, 1, 1, WALK, 1);      // 82 stun over
    addVec(1, 4'b0100, 0, 454, 127, 0, 1, 1, WALK, 1);      // 83
    addVec(1, 4'b0100, 1, 454, 127, 0, 1, 0, DEAD, 0);      // 84 defeat
    addVec(1, 4'b0000, 1, 454, 127, 0, 1, 0, DEAD, 0);      // 85 frozen
    addVec(1, 4'b0011, 0, 454, 127, 0, 1, 0, DEAD, 0);      // 86 frozen
    addVec(0, 4'b0000, 0, 450, 150, 0, 1, 1, WALK, 2);      // 87 reset out of DEAD
    for (int k = 0; k < 10; k++)
      addVec(1, 4'b0000, 0, 453 + 3 * k, fallY[k], fallYs[k], 1, 1, WALK, 2); // 88..97
    addVec(1, 4'b1000, 0, 483, 202, 0, 1, 1, WALK, 2);      // 98 head bump
    addVec(1, 4'b0000, 0, 486, 202, 1, 1, 1, WALK, 2);      // 99

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].resetN, vecs[i].col, vecs[i].hit);
      checkOutput($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].ySpd,
                  vecs[i].dir, vecs[i].active, vecs[i].mode, vecs[i].hp);
    end

    // ---------------- reset in the middle of a stun ----------------
    applyStimulus(0, 4'b0000, 0);
    checkOutput("stunRst0", 450, 150, 0, 1, 1, WALK, 2);
    applyStimulus(1, 4'b0100, 1);
    checkOutput("stunRst1", 450, 150, 0, 1, 1, STUNNED, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 4'b0100, 0);
      checkOutput($sformatf("stunRstHold%0d", k), 450, 150, 0, 1, 1, STUNNED, 1);
    end
    applyStimulus(0, 4'b0011, 1);
    checkOutput("stunRst2", 450, 150, 0, 1, 1, WALK, 2);
    applyStimulus(1, 4'b0100, 0);
    checkOutput("stunRst3", 453, 150, 0, 1, 1, WALK, 2);

    // ---------------- reset in the middle of a turn ----------------
    applyStimulus(1, 4'b0110, 0);
    checkOutput("turnRst0", 447, 150, 0, 1, 1, TURN, 2);
    applyStimulus(1, 4'b0100, 0);
    checkOutput("turnRst1", 447, 150, 0, 1, 1, TURN, 2);
    applyStimulus(0, 4'b0110, 1);
    checkOutput("turnRst2", 450, 150, 0, 1, 1, WALK, 2);
    applyStimulus(1, 4'b0100, 0);
    checkOutput("turnRst3", 453, 150, 0, 1, 1, WALK, 2);

`ifdef ENEMY_LEDGE_TURN_EN
    // ---------------- ledge turn ----------------
    applyStimulus(0, 4'b0000, 0);
    checkOutput("ledge0", 450, 150, 0, 1, 1, WALK, 2);
    ledgeAhead = 1'b1;
    applyStimulus(1, 4'b0100, 0);
    checkOutput("ledge1", 450, 150, 0, 1, 1, TURN, 2);
    ledgeAhead = 1'b0;
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1, 4'b0100, 0);
      checkOutput($sformatf("ledgeHold%0d", k), 450, 150, 0, 1, 1, TURN, 2);
    end
    applyStimulus(1, 4'b0100, 0);
    checkOutput("ledge2", 450, 150, 0, 0, 1, WALK, 2);
    applyStimulus(1, 4'b0100, 0);
    checkOutput("ledge3", 447, 150, 0, 0, 1, WALK, 2);
    // wall beats ledge: snap is applied
    applyStimulus(0, 4'b0000, 0);
    checkOutput("ledge4", 450, 150, 0, 1, 1, WALK, 2);
    ledgeAhead = 1'b1;
    applyStimulus(1, 4'b0110, 0);
    checkOutput("ledge5", 447, 150, 0, 1, 1, TURN, 2);
    ledgeAhead = 1'b0;
`else
    // ---------------- no ledge sensing: walks off and falls ----------------
    applyStimulus(0, 4'b0000, 0);
    checkOutput("noLedge0", 450, 150, 0, 1, 1, WALK, 2);
    applyStimulus(1, 4'b0100, 0);
    checkOutput("noLedge1", 453, 150, 0, 1, 1, WALK, 2);
    applyStimulus(1, 4'b0000, 0);
    checkOutput("noLedge2", 456, 150, 1, 1, 1, WALK, 2);
    applyStimulus(1, 4'b0000, 0);
    checkOutput("noLedge3", 459, 151, 2, 1, 1, WALK, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/enemy_walker.md
Name: enemy_walker

Overview:
- Parametrised patrolling ground enemy. Next generation of the single-purpose wall-bouncing walker.
- Adds gravity and falling, a pause-then-turn on wall contact, hit points, and stun/defeat states.
- One instance per enemy, clocked once per game frame by the simulation clock.
- Packed state word feeds the renderer and the collision unit, using the same field order as the existing enemy state word.

Parameters:
POS_W, 10, width of x/y position
SPD_W, 5, width of x/y speed fields
TILE_LOG2, 5, log2 of tile size (32 px)
INIT_X, 450, x position after reset
INIT_Y, 150, y position after reset
WALK_SPEED, 3, horizontal pixels per frame
GRAVITY, 1, y speed increment per airborne frame
MAX_FALL, 8, y speed saturation value
TURN_PAUSE, 8, frames held in TURN before reversing
STUN_FRAMES, 60, frames held in STUNNED
HP_INIT, 2, hit points after reset

Ports:
sim_clk  in  1  frame clock
reset_n  in  1  synchronous active-low reset
col  in  4  collision flags {ceiling, floor, right, left}
hit  in  1  one-frame pulse: player stomped this enemy
enemy_state  out  2*POS_W+2*SPD_W+2  {x_pos, y_pos, x_spd, y_spd, dir, active}; 32 bits at defaults
mode  out  3  current FSM state encoding
hp  out  2  remaining hit points

Behaviour:
- Reset (reset_n low at a sim_clk edge): x=INIT_X, y=INIT_Y, x_spd=WALK_SPEED, y_spd=0, dir=right(1), active=1, hp=HP_INIT, mode=WALK, timers=0. Reset wins over every other input, including mid-TURN or mid-STUN.
- States: WALK=0, TURN=1, STUNNED=2, DEAD=3.
- All updates are registered. Outputs reflect the new values one cycle after the inputs that caused them.
- Horizontal motion, WALK only: x <= dir ? x+x_spd : x-x_spd. Arithmetic is modulo 2^POS_W; no clamping.
- Wall contact in WALK (col[0] or col[1]), with T = 2^TILE_LOG2 and m = T-1:
  - moving left: x <= (x-x_spd) - ((x-x_spd)&m) + T
  - moving right: x <= (x+x_spd) - ((x+x_spd)&m) - 1
  - then mode <= TURN and the turn timer loads 0.
  - Both flags set at once: snap according to the current dir.
- TURN: x frozen. The timer counts each frame. When it reaches TURN_PAUSE-1: dir <= ~dir and mode <= WALK. Wall flags are ignored while in TURN.
- Vertical motion, WALK/TURN/STUNNED:
  - col[2]=0 (airborne): y <= y+y_spd; y_spd <= min(y_spd+GRAVITY, MAX_FALL).
  - col[2]=1: y <= (y+y_spd) - ((y+y_spd)&m) - 1 and y_spd <= 0, only when y_spd≠0. With y_spd=0, y is held.
  - col[3]: y_spd <= 0 (head bump).
- Hit:
  - hit in WALK/TURN with hp>1: hp--, mode <= STUNNED, stun timer loads 0.
  - hit with hp==1: hp <= 0, mode <= DEAD.
  - Hit takes priority over a wall contact in the same frame; no snap is applied.
  - hit in STUNNED or DEAD is ignored (invulnerability).
- STUNNED: x frozen, gravity still applies. After STUN_FRAMES frames, mode <= WALK with dir unchanged.
- DEAD: active=0, x/y/speeds frozen. Left only by reset.
- Packed word: x_spd field reads 0 in TURN, STUNNED and DEAD; WALK_SPEED otherwise.

Optional Feature:
- Macro ENEMY_LEDGE_TURN_EN.
- When defined:
  - Adds input port ledge_ahead (1 bit): no floor one tile ahead in dir.
  - In WALK with col[2]=1 and ledge_ahead=1: x holds, mode <= TURN, with no snap.
  - Wall contact has priority over ledge.
- When undefined: the port is absent. The enemy walks off ledges and falls under gravity.

Decomposition:
- Package enemy_pkg:
  - state encoding constants WALK/TURN/STUNNED/DEAD
  - direction constants LEFT=0/RIGHT=1
  - col bit indices
  - packed-word field offsets
  - default TILE_LOG2
- Natural sub-module tile_snap:
  - combinational; parametrised by POS_W/TILE_LOG2
  - inputs pos, spd, toward_positive
  - output snapped coordinate
  - instanced twice (x wall snap, y floor snap)
- Turn and stun counters stay inline.

Test Plan:
- Reset then 1 frame, col=0000 → x=453, y=150, y_spd=1, mode=WALK, enemy_state[1:0]=2'b11.
- x=453, dir=right, col=0010 → x=447, mode=TURN. 8 frames later dir=0, mode=WALK. Next frame x=444.
- x=100, dir=left, col=0001 → x=128, mode=TURN.
- y=157, y_spd=3, col=0100 → y=159, y_spd=0. Airborne from y=150, y_spd=0 → y sequence 150, 151, 153, 156; y_spd saturates at 8.
- hit at hp=2 → hp=1, STUNNED for 60 frames with x frozen. Hit during stun → ignored. Hit after stun → hp=0, DEAD, active=0. Reset_n low mid-stun → full reset values next cycle.
- ENEMY_LEDGE_TURN_EN defined, col=0100, ledge_ahead=1 → x unchanged, TURN, dir reverses after 8 frames. Undefined build → enemy falls, y_spd increases.
